// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the write-back queue.
//   REG_W / DATA_W : register address and data widths
//   REG_ZERO       : the hard-wired $zero register, never written
//   wb_entry_t     : one queued register file write {reg_addr, data}
package mips_pkg;

    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = REG_W + DATA_W;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Writes to $zero are dropped at the queue input.
    function automatic logic is_writable(input logic [REG_W-1:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Bus bundle for the write-back queue.
//   producer side : alu_valid/alu_reg/alu_data, ld_valid/ld_reg/ld_data, in_ready
//   decode side   : read_reg1/read_reg2 in, hazard1/hazard2 out
//   regfile side  : write_reg, write_data, RegWrite
//   status        : empty, count
// Handshake: a source's request is taken on a rising clk edge when its
// valid=1 and in_ready=1 in the cycle before that edge. in_ready does not
// depend on either valid. A request presented while in_ready=0 is ignored
// and the producer must keep it asserted until it is taken.
// master = producers/decode/register file, slave = the queue.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
);
    import mips_pkg::*;

    logic              alu_valid;
    logic [REG_W-1:0]  alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic [REG_W-1:0]  ld_reg;
    logic [DATA_W-1:0] ld_data;
    logic              in_ready;
    logic [REG_W-1:0]  read_reg1;
    logic [REG_W-1:0]  read_reg2;
    logic              hazard1;
    logic              hazard2;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;
    logic              RegWrite;
    logic              empty;
    logic [CW-1:0]     count;

    modport master (
        output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        output read_reg1, read_reg2,
        input  in_ready, hazard1, hazard2, write_reg, write_data, RegWrite,
        input  empty, count
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        input  read_reg1, read_reg2,
        output in_ready, hazard1, hazard2, write_reg, write_data, RegWrite,
        output empty, count
    );

endinterface

// File: rtl/wb_fifo_mem.sv
// Storage array for the write-back queue: DEPTH entries of {reg, data}.
//   clk               : rising-edge clock
//   we0/waddr0/wdata0 : write port 0 (older of two same-cycle pushes)
//   we1/waddr1/wdata1 : write port 1 (younger push)
//   raddr/rdata       : asynchronous read of the head entry
//   tags              : register field of every slot, for hazard compare
// The array holds no reset: slot validity is tracked by the pointers and
// count in the parent.
module wb_fifo_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  wb_entry_t        wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  wb_entry_t        wdata1,
    input  logic [AW-1:0]    raddr,
    output wb_entry_t        rdata,
    output logic [REG_W-1:0] tags [DEPTH]
);

    wb_entry_t mem [DEPTH];

    // The two write addresses are always distinct (consecutive slots).
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tags
        assign tags[g] = mem[g].reg_addr;
    end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue between the EX/MEM result producers and the register
// file write port. Takes up to one ALU and one load write per cycle,
// buffers them in order, and drains one per cycle through a registered
// output stage (write_reg, write_data, RegWrite). Flags read-port hazards
// while a write to a read register is still pending.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_write_queue_if slave modport (see interface file)
module wb_write_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_write_queue_if.slave bus
);

    localparam int PW = CW - 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;

    logic              in_ready;
    logic              alu_push;
    logic              ld_push;
    logic              pop;
    logic [1:0]        n_push;

    wb_entry_t         alu_entry;
    wb_entry_t         ld_entry;
    wb_entry_t         head_entry;

    logic              we0;
    logic              we1;
    logic [PW-1:0]     waddr0;
    logic [PW-1:0]     waddr1;
    wb_entry_t         wdata0;
    wb_entry_t         wdata1;
    logic [REG_W-1:0]  tags [DEPTH];

    logic [REG_W-1:0]  write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic              reg_write_q;

    logic              hit1;
    logic              hit2;

    // Two free slots are needed because both sources may push together
    // in a cycle where nothing pops.
    assign in_ready = count_q <= CW'(DEPTH - 2);

    // $zero requests are accepted (they complete the handshake) but never
    // occupy a slot.
    assign alu_push = bus.alu_valid && in_ready && is_writable(bus.alu_reg);
    assign ld_push  = bus.ld_valid  && in_ready && is_writable(bus.ld_reg);
    assign n_push   = {1'b0, alu_push} + {1'b0, ld_push};
    assign pop      = count_q != '0;

    assign alu_entry = '{reg_addr: bus.alu_reg, data: bus.alu_data};
    assign ld_entry  = '{reg_addr: bus.ld_reg,  data: bus.ld_data};

    // ALU goes ahead of load; a lone push of either kind uses port 0.
    always_comb begin
        we0    = alu_push || ld_push;
        waddr0 = wr_ptr;
        wdata0 = alu_push ? alu_entry : ld_entry;
        we1    = alu_push && ld_push;
        waddr1 = wr_ptr + PW'(1);
        wdata1 = ld_entry;
    end

    wb_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .raddr  (rd_ptr),
        .rdata  (head_entry),
        .tags   (tags)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(n_push);
            rd_ptr  <= rd_ptr + PW'(pop);
            count_q <= count_q + CW'(n_push) - CW'(pop);
        end
    end

    // Output stage: address/data hold their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg_q  <= REG_ZERO;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            reg_write_q <= pop;
            if (pop) begin
                write_reg_q  <= head_entry.reg_addr;
                write_data_q <= head_entry.data;
            end
        end
    end

    // A slot is live when its distance from the head is below count.
    // The output stage counts too: the register file commits at the end
    // of the RegWrite cycle, so a read in that cycle still sees old data.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < count_q) begin
                if (tags[i] == bus.read_reg1) hit1 = 1'b1;
                if (tags[i] == bus.read_reg2) hit2 = 1'b1;
            end
        end
        if (reg_write_q && write_reg_q == bus.read_reg1) hit1 = 1'b1;
        if (reg_write_q && write_reg_q == bus.read_reg2) hit2 = 1'b1;
    end

    assign bus.hazard1    = hit1 && (bus.read_reg1 != REG_ZERO);
    assign bus.hazard2    = hit2 && (bus.read_reg2 != REG_ZERO);
    assign bus.in_ready   = in_ready;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.RegWrite   = reg_write_q;
    assign bus.count      = count_q;
    assign bus.empty      = (count_q == '0) && !reg_write_q;

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;

    logic [ENTRY_W-1:0] exp_q [$];

    wb_write_queue_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every register file write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && bus.RegWrite) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: got reg %0d data 0x%0h, expected no write",
                         bus.write_reg, bus.write_data);
            end else begin
                logic [ENTRY_W-1:0] e;
                e = exp_q.pop_front();
                chk("write_entry", {bus.write_reg, bus.write_data}, e);
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge; presents one cycle of requests,
    // checks count/in_ready against the occupancy model, queues the
    // expected writes and returns just after the next rising edge.
    task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                        output bit acc);
        int n;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_reg    = lr;
        bus.ld_data   = ld;
        @(negedge clk);
        chk("count", 64'(bus.count), 64'(m_cnt));
        chk("in_ready", 64'(bus.in_ready), 64'(m_cnt <= DEPTH - 2));
        acc = (m_cnt <= DEPTH - 2);
        n = 0;
        if (acc && av && ar != 5'd0) begin exp_q.push_back({ar, ad}); n++; end
        if (acc && lv && lr != 5'd0) begin exp_q.push_back({lr, ld}); n++; end
        m_cnt = m_cnt + n - ((m_cnt > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
    endtask

    task automatic idle();
        bit acc;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        int idx;
        int guard;

        rst_n = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_reg  = '0; bus.ld_data  = '0;
        bus.read_reg1 = '0;   bus.read_reg2 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_regwrite",   64'(bus.RegWrite),   64'd0);
        chk("rst_write_reg",  64'(bus.write_reg),  64'd0);
        chk("rst_write_data", 64'(bus.write_data), 64'd0);
        chk("rst_count",      64'(bus.count),      64'd0);
        chk("rst_empty",      64'(bus.empty),      64'd1);
        chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push: reg 8 / 0xAA, RegWrite two edges later.
        step(1'b1, 5'd8, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, acc);
        chk("single_count1",  64'(bus.count),    64'd1);
        chk("single_rw_early",64'(bus.RegWrite), 64'd0);
        idle();
        chk("single_rw",      64'(bus.RegWrite),   64'd1);
        chk("single_reg",     64'(bus.write_reg),  64'd8);
        chk("single_data",    64'(bus.write_data), 64'h0000_00AA);
        chk("single_empty0",  64'(bus.empty),      64'd0);
        idle();
        chk("single_rw_off",  64'(bus.RegWrite),   64'd0);
        chk("single_empty1",  64'(bus.empty),      64'd1);
        chk("single_hold",    64'(bus.write_reg),  64'd8);

        // Dual push: ALU ahead of load.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, acc);
        chk("dual_peak",      64'(bus.count),     64'd2);
        idle();
        chk("dual_first",     64'(bus.write_reg), 64'd3);
        chk("dual_count1",    64'(bus.count),     64'd1);
        idle();
        chk("dual_second",    64'(bus.write_reg), 64'd4);
        idle();
        chk("dual_empty",     64'(bus.empty),     64'd1);

        // Register zero is swallowed.
        bus.read_reg1 = 5'd0;
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, acc);
        chk("zero_count",     64'(bus.count),   64'd0);
        chk("zero_hazard1",   64'(bus.hazard1), 64'd0);
        repeat (2) begin
            idle();
            chk("zero_no_write", 64'(bus.RegWrite), 64'd0);
        end

        // Hazard tracking for reg 9 through FIFO and output stage.
        bus.read_reg1 = 5'd10;
        bus.read_reg2 = 5'd9;
        step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, acc);
        chk("haz_q_h2",       64'(bus.hazard2), 64'd1);
        chk("haz_q_h1",       64'(bus.hazard1), 64'd0);
        idle();
        chk("haz_out_rw",     64'(bus.RegWrite), 64'd1);
        chk("haz_out_h2",     64'(bus.hazard2),  64'd1);
        chk("haz_out_h1",     64'(bus.hazard1),  64'd0);
        idle();
        chk("haz_done_h2",    64'(bus.hazard2),  64'd0);
        bus.read_reg1 = 5'd0;
        bus.read_reg2 = 5'd0;

        // Back-pressure: both sources every cycle, held while blocked.
        idx = 0;
        guard = 0;
        while (idx < 12 && guard < 40) begin
            step(1'b1, 5'(idx + 1), 32'h100 + 32'(idx),
                 1'b1, 5'(idx + 2), 32'h101 + 32'(idx), acc);
            if (acc) idx += 2;
            guard++;
        end
        chk("bp_all_pushed", 64'(idx), 64'd12);
        repeat (6) idle();
        chk("bp_drained",    64'(exp_q.size()), 64'd0);
        chk("bp_empty",      64'(bus.empty),    64'd1);

        // Reset mid-drain.
        step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, acc);
        step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0,  acc);
        chk("mid_rw_before", 64'(bus.RegWrite), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rw_drop",   64'(bus.RegWrite), 64'd0);
        chk("mid_count",     64'(bus.count),    64'd0);
        chk("mid_empty",     64'(bus.empty),    64'd1);
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) idle();
        chk("mid_no_stale",  64'(bus.empty),    64'd1);
        chk("final_queue",   64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back side of the MIPS register file; sits between the EX/MEM result producers and the register file write port.
- Accepts write-back requests from two sources: the ALU result path and the load-data path. At most one request per source per cycle.
- Buffers requests in an in-order FIFO and drains them one per cycle onto the single write port (write_reg, write_data, RegWrite).
- Reports per-read-port hazards so decode can stall while a write to a read register is still pending.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, width of count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU write-back request
- alu_reg  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load write-back request
- ld_reg  in  5  load destination register
- ld_data  in  32  load data
- in_ready  out  1  both sources may push this cycle
- read_reg1  in  5  register file read address 1
- read_reg2  in  5  register file read address 2
- hazard1  out  1  write to read_reg1 is pending
- hazard2  out  1  write to read_reg2 is pending
- write_reg  out  5  register file write address
- write_data  out  32  register file write data
- RegWrite  out  1  register file write enable
- empty  out  1  queue empty and no write presented
- count  out  CW  FIFO occupancy; excludes the output stage

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count = 0, RegWrite = 0, write_reg = 0, write_data = 0.
- in_ready is combinational: in_ready = (count <= DEPTH-2). This guarantees room for two pushes even with no pop.
- Push rule: a source pushes when its valid=1 and in_ready=1.
  - valid=1 with in_ready=0 is a protocol violation; the request is ignored and the producer must hold it.
- Register 0: a push whose reg=0 is accepted but not enqueued, because $zero is never written.
- Simultaneous pushes from both sources: ALU entry is enqueued first, then load. Both land in the same cycle.
- Pop: every cycle with count>0, the head moves into the output registers at the clock edge.
  - RegWrite=1 during the following cycle.
  - If count=0, RegWrite=0 next cycle; write_reg and write_data hold their last values.
- Count update: count_next = count + pushes_enqueued - pop. Push and pop in the same cycle are legal, including two pushes and one pop (net +1).
- Latency: a push accepted in cycle N appears with RegWrite=1 in cycle N+2 when the queue was empty. Throughput is 1 write per cycle.
- Order: register file writes occur in exact enqueue order. A later write to the same register overrides the earlier one.
- Hazard rule: hazardK=1 if read_regK != 0 and read_regK matches any valid FIFO entry, or matches write_reg while RegWrite=1.
  - The output stage is included because the register file commits only at the end of that cycle.
  - Same-cycle incoming requests are not checked; the producing pipeline covers those.
- empty = (count==0) && !RegWrite.
- Wrap-around: pointers wrap modulo DEPTH. The full condition is derived from count, not from pointer equality.
- Mid-operation reset: all pending entries are discarded and RegWrite drops immediately (async).

Decomposition:
- Shared package mips_pkg: REG_W=5, DATA_W=32, REG_ZERO=5'd0, and the write-back entry record {reg, data}.
- One natural sub-module: wb_fifo_mem, a DEPTH x 37-bit storage array with two write ports and one read port.
  - Pointers, count and hazard compare stay in the top module.

Test Plan:
- Single push: alu_valid, reg 8, data 0x0000_00AA in cycle 1 -> RegWrite=1, write_reg=8, write_data=0xAA in cycle 3; empty=1 in cycle 4.
- Dual push: ALU (reg 3, 0x11) and load (reg 4, 0x22) in the same cycle -> writes to reg 3 then reg 4 in consecutive cycles; count peaks at 2.
- Back-pressure: both sources push every cycle with DEPTH=4 -> in_ready falls when count=3; no entry is lost; the drain order matches the push order.
- Register zero: alu_reg=0 with data 0xDEAD -> count stays 0, RegWrite never asserts, hazard1=0 for read_reg1=0.
- Hazard: entry for reg 9 queued, read_reg2=9 -> hazard2=1 until the cycle after RegWrite for reg 9; read_reg1=10 -> hazard1=0 throughout.
- Reset mid-drain: 3 entries queued, rst_n=0 for 1 cycle -> RegWrite=0 immediately, count=0; after release, no stale writes occur.
